// File: rtl/ll_telemetry_tx_pkg.sv
// Shared types and constants for the telemetry transmitter.
// Holds the FSM state enum, ASCII codes and the BCD helpers.
package ll_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        STROBE,
        GAP
    } tx_state_t;

    // Lander state captured when a frame starts.
    typedef struct packed {
        logic [15:0] alt;
        logic [15:0] vel;
        logic [15:0] fuel;
        logic [3:0]  thrust;
        logic        land;
        logic        crash;
    } snap_t;

    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_V     = 8'h56;
    localparam logic [7:0] CH_F     = 8'h46;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_X     = 8'h58;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_Q     = 8'h3F;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;

    localparam int unsigned FRAME_LEN_EOL   = 25;
    localparam int unsigned FRAME_LEN_NOEOL = 23;

    // One BCD digit to ASCII; non-decimal nibbles print as '?'.
    function automatic logic [7:0] digit_ascii(
        input logic [3:0] d
    );
        if (d > 4'd9) begin
            digit_ascii = CH_Q;
        end else begin
            digit_ascii = CH_0 + {4'h0, d};
        end
    endfunction

    // 0000 - v (mod 10^4) in BCD, the same result bcdaddsub4
    // gives with a=0, op=1. Ripples a decimal borrow upward.
    function automatic logic [15:0] bcd_neg4(
        input logic [15:0] v
    );
        logic [15:0] r;
        logic        b;
        logic [4:0]  t;
        r = '0;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = 5'd0 - {1'b0, v[4*i +: 4]} - {4'b0, b};
            if (t[4]) begin
                t = t + 5'd10;
                b = 1'b1;
            end else begin
                b = 1'b0;
            end
            r[4*i +: 4] = t[3:0];
        end
        bcd_neg4 = r;
    endfunction

endpackage

// File: rtl/ll_telemetry_tx_if.sv
// Host-side bundle of the telemetry transmitter: lander state in,
// UART byte port and status flags out. master = driver, slave = tx.
interface ll_telemetry_tx_if;
    logic        send;
    logic [15:0] alt;
    logic [15:0] vel;
    logic [15:0] fuel;
    logic [15:0] thrust;
    logic        land;
    logic        crash;
    logic        txready;
    logic [7:0]  txdata;
    logic        txclk;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    modport master (
        output send, alt, vel, fuel, thrust,
        output land, crash, txready,
        input  txdata, txclk, busy,
        input  frame_done, overrun
    );

    modport slave (
        input  send, alt, vel, fuel, thrust,
        input  land, crash, txready,
        output txdata, txclk, busy,
        output frame_done, overrun
    );
endinterface

// File: rtl/ll_telemetry_tx_frame_byte.sv
// Combinational frame formatter: snapshot + index -> ASCII byte.
// Ports: i_snap (captured state), i_idx (0..24), o_byte.
module ll_frame_byte
    import ll_tx_pkg::*;
#(
    parameter logic [7:0] SEP = 8'h20
) (
    input  snap_t      i_snap,
    input  logic [4:0] i_idx,
    output logic [7:0] o_byte
);

    logic        w_neg;
    logic [15:0] w_mag;
    logic [7:0]  w_sign;
    logic [7:0]  w_status;

    assign w_neg  = i_snap.vel[15];
    assign w_mag  = w_neg ? bcd_neg4(i_snap.vel)
                          : i_snap.vel;
    assign w_sign = w_neg ? CH_MINUS : CH_PLUS;

    // crash outranks land
    assign w_status = i_snap.crash ? CH_X
                    : i_snap.land  ? CH_L
                    : CH_DASH;

    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            5'd0:  o_byte = CH_A;
            5'd1:  o_byte = digit_ascii(i_snap.alt[15:12]);
            5'd2:  o_byte = digit_ascii(i_snap.alt[11:8]);
            5'd3:  o_byte = digit_ascii(i_snap.alt[7:4]);
            5'd4:  o_byte = digit_ascii(i_snap.alt[3:0]);
            5'd5:  o_byte = SEP;
            5'd6:  o_byte = CH_V;
            5'd7:  o_byte = w_sign;
            5'd8:  o_byte = digit_ascii(w_mag[15:12]);
            5'd9:  o_byte = digit_ascii(w_mag[11:8]);
            5'd10: o_byte = digit_ascii(w_mag[7:4]);
            5'd11: o_byte = digit_ascii(w_mag[3:0]);
            5'd12: o_byte = SEP;
            5'd13: o_byte = CH_F;
            5'd14: o_byte = digit_ascii(i_snap.fuel[15:12]);
            5'd15: o_byte = digit_ascii(i_snap.fuel[11:8]);
            5'd16: o_byte = digit_ascii(i_snap.fuel[7:4]);
            5'd17: o_byte = digit_ascii(i_snap.fuel[3:0]);
            5'd18: o_byte = SEP;
            5'd19: o_byte = CH_T;
            5'd20: o_byte = digit_ascii(i_snap.thrust);
            5'd21: o_byte = SEP;
            5'd22: o_byte = w_status;
            5'd23: o_byte = CR;
            5'd24: o_byte = LF;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ll_telemetry_tx.sv
// Lunar-lander telemetry transmitter: snapshots state on send and
// shifts one ASCII line out the UART byte port. Ports: clk, rst, bus.
module ll_telemetry_tx
    import ll_tx_pkg::*;
#(
    parameter bit         EOL_EN = 1'b1,
    parameter logic [7:0] SEP    = 8'h20
) (
    input logic              clk,
    input logic              rst,
    ll_telemetry_tx_if.slave bus
);

    localparam logic [4:0] LAST_IDX = EOL_EN
        ? 5'(FRAME_LEN_EOL - 1)
        : 5'(FRAME_LEN_NOEOL - 1);

    tx_state_t  r_state, w_state;
    snap_t      r_snap, w_snap;
    logic [4:0] r_idx, w_idx;
    logic [7:0] r_txdata, w_txdata;
    logic       r_txclk, w_txclk;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic       r_overrun, w_overrun;
    logic [7:0] w_byte;
    logic       w_unused_thrust;

    // only the ones digit of thrust is transmitted
    assign w_unused_thrust = ^bus.thrust[15:4];

    ll_frame_byte #(
        .SEP    (SEP)
    ) u_fb (
        .i_snap (r_snap),
        .i_idx  (r_idx),
        .o_byte (w_byte)
    );

    always_comb begin
        w_state   = r_state;
        w_snap    = r_snap;
        w_idx     = r_idx;
        w_txdata  = r_txdata;
        w_txclk   = 1'b0;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_overrun = r_overrun;
        if (bus.send && r_state != IDLE) begin
            w_overrun = 1'b1;
        end
        unique case (r_state)
            IDLE: begin
                if (bus.send) begin
                    w_snap.alt    = bus.alt;
                    w_snap.vel    = bus.vel;
                    w_snap.fuel   = bus.fuel;
                    w_snap.thrust = bus.thrust[3:0];
                    w_snap.land   = bus.land;
                    w_snap.crash  = bus.crash;
                    w_idx         = 5'd0;
                    w_busy        = 1'b1;
                    w_state       = PRESENT;
                end
            end
            PRESENT: begin
                w_txdata = w_byte;
                if (bus.txready) begin
                    w_state = STROBE;
                end
            end
            STROBE: begin
                w_txclk = 1'b1;
                w_state = GAP;
            end
            GAP: begin
                if (r_idx == LAST_IDX) begin
                    w_idx   = 5'd0;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_idx   = r_idx + 5'd1;
                    w_state = PRESENT;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_snap    <= '0;
            r_idx     <= 5'd0;
            r_txdata  <= 8'h00;
            r_txclk   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_snap    <= w_snap;
            r_idx     <= w_idx;
            r_txdata  <= w_txdata;
            r_txclk   <= w_txclk;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_overrun <= w_overrun;
        end
    end

    assign bus.txdata     = r_txdata;
    assign bus.txclk      = r_txclk;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_ll_telemetry_tx.sv
// Directed bench for ll_telemetry_tx (CR LF and no-EOL builds).
// Ports: none; drives two interfaces and prints one summary line.
module tb_ll_telemetry_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ll_telemetry_tx_if bus ();
    ll_telemetry_tx_if bus0 ();

    assign bus0.alt     = bus.alt;
    assign bus0.vel     = bus.vel;
    assign bus0.fuel    = bus.fuel;
    assign bus0.thrust  = bus.thrust;
    assign bus0.land    = bus.land;
    assign bus0.crash   = bus.crash;
    assign bus0.txready = bus.txready;

    ll_telemetry_tx #(.EOL_EN(1'b1), .SEP(8'h20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ll_telemetry_tx #(.EOL_EN(1'b0), .SEP(8'h20)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    // strobe monitor
    logic [7:0] q_b[$];
    int         q_t[$];
    logic [7:0] q0_b[$];
    int         fd_cnt = 0;
    int         fd_t = 0;
    int         fd0_cnt = 0;
    bit         prev_clk = 0;
    bit         dbl = 0;

    always @(negedge clk) begin
        if (bus.txclk === 1'b1) begin
            q_b.push_back(bus.txdata);
            q_t.push_back(cyc);
            if (prev_clk) dbl = 1;
        end
        prev_clk = (bus.txclk === 1'b1);
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_t = cyc;
        end
        if (bus0.txclk === 1'b1) q0_b.push_back(bus0.txdata);
        if (bus0.frame_done === 1'b1) fd0_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(
        input logic [15:0] a, input logic [15:0] v,
        input logic [15:0] f, input logic [15:0] t,
        input logic l, input logic c
    );
        bus.alt = a;
        bus.vel = v;
        bus.fuel = f;
        bus.thrust = t;
        bus.land = l;
        bus.crash = c;
    endtask

    task automatic send_pulse(output int n);
        tick();
        bus.send = 1'b1;
        n = cyc;
        tick();
        bus.send = 1'b0;
    endtask

    task automatic wait_q(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (q_b.size() >= n) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_fd(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (fd_cnt >= n) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bus.send = 1'b0;
        bus0.send = 1'b0;
        bus.txready = 1'b1;
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.txdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_txdata got %h want 00", bus.txdata);
        end
        checks++;
        if (bus.txclk !== 1'b0) begin
            failures++;
            $display("FAIL rst_txclk got %b want 0", bus.txclk);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_done got %b want 0", bus.frame_done);
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL rst_overrun got %b want 0", bus.overrun);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        string exp = "A4500 V+0000 F0800 T5 -\r\n";
        int    n;
        int    fd0;
        bit    ok;
        bit    gap_bad;
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b0, 1'b0);
        q_b.delete();
        q_t.delete();
        fd0 = fd_cnt;
        send_pulse(n);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got %b want 1", bus.busy);
        end
        wait_fd(fd0 + 1, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL basic_timeout got %0d want 1", ok);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_end got %b want 0", bus.busy);
        end
        checks++;
        if (q_b.size() != 25) begin
            failures++;
            $display("FAIL basic_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp[i]) begin
                failures++;
                $display("FAIL basic_byte%0d got %h want %h",
                         i, q_b[i], exp[i]);
            end
        end
        checks++;
        if (q_t[0] != n + 3) begin
            failures++;
            $display("FAIL basic_latency got %0d want %0d",
                     q_t[0] - n, 3);
        end
        gap_bad = 0;
        for (int i = 1; i < q_t.size(); i++) begin
            if (q_t[i] - q_t[i-1] != 3) gap_bad = 1;
        end
        checks++;
        if (gap_bad !== 1'b0) begin
            failures++;
            $display("FAIL basic_spacing got %b want 0", gap_bad);
        end
        checks++;
        if (fd_t != n + 76) begin
            failures++;
            $display("FAIL basic_done_time got %0d want %0d",
                     fd_t - n, 76);
        end
        repeat (5) tick();
        checks++;
        if (fd_cnt != fd0 + 1) begin
            failures++;
            $display("FAIL basic_done_cnt got %0d want %0d",
                     fd_cnt - fd0, 1);
        end
    endtask

    task automatic test_negative_vel();
        string exp1 = "A4500 V-0005 F0800 T5 L\r\n";
        string exp2 = "A4500 V-0030 F0800 T5 X\r\n";
        int    n;
        bit    ok;
        set_in(16'h4500, 16'h9995, 16'h0800, 16'h0005, 1'b1, 1'b0);
        q_b.delete();
        send_pulse(n);
        wait_fd(fd_cnt + 1, ok);
        checks++;
        if (ok !== 1'b1 || q_b.size() != 25) begin
            failures++;
            $display("FAIL neg1_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp1[i]) begin
                failures++;
                $display("FAIL neg1_byte%0d got %h want %h",
                         i, q_b[i], exp1[i]);
            end
        end
        set_in(16'h4500, 16'h9970, 16'h0800, 16'h0005, 1'b1, 1'b1);
        q_b.delete();
        send_pulse(n);
        wait_fd(fd_cnt + 1, ok);
        checks++;
        if (ok !== 1'b1 || q_b.size() != 25) begin
            failures++;
            $display("FAIL neg2_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp2[i]) begin
                failures++;
                $display("FAIL neg2_byte%0d got %h want %h",
                         i, q_b[i], exp2[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        string exp = "A4500 V+0000 F0800 T5 -\r\n";
        int    n;
        int    r;
        int    bad;
        bit    ok;
        set_in(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b0, 1'b0);
        q_b.delete();
        q_t.delete();
        send_pulse(n);
        wait_q(5, ok);
        bus.txready = 1'b0;
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.txclk !== 1'b0 || bus.txdata !== 8'h20) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold got %0d want 0 bad cycles", bad);
        end
        checks++;
        if (q_b.size() != 5) begin
            failures++;
            $display("FAIL bp_count got %0d want 5", q_b.size());
        end
        bus.txready = 1'b1;
        r = cyc;
        wait_fd(fd_cnt + 1, ok);
        checks++;
        if (q_t[5] != r + 2) begin
            failures++;
            $display("FAIL bp_release got %0d want %0d",
                     q_t[5] - r, 2);
        end
        checks++;
        if (ok !== 1'b1 || q_b.size() != 25) begin
            failures++;
            $display("FAIL bp_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp[i]) begin
                failures++;
                $display("FAIL bp_byte%0d got %h want %h",
                         i, q_b[i], exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        string exp1 = "A1234 V+0042 F0999 T7 -\r\n";
        string exp2 = "A0100 V-0001 F0000 T3 L\r\n";
        int    n;
        bit    ok;
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_pre got %b want 0", bus.overrun);
        end
        set_in(16'h1234, 16'h0042, 16'h0999, 16'h0007, 1'b0, 1'b0);
        q_b.delete();
        send_pulse(n);
        wait_q(8, ok);
        set_in(16'h0100, 16'h9999, 16'h0000, 16'h0093, 1'b1, 1'b0);
        send_pulse(n);
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set got %b want 1", bus.overrun);
        end
        wait_fd(fd_cnt + 1, ok);
        checks++;
        if (ok !== 1'b1 || q_b.size() != 25) begin
            failures++;
            $display("FAIL ovr1_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp1[i]) begin
                failures++;
                $display("FAIL ovr1_byte%0d got %h want %h",
                         i, q_b[i], exp1[i]);
            end
        end
        q_b.delete();
        send_pulse(n);
        wait_fd(fd_cnt + 1, ok);
        checks++;
        if (ok !== 1'b1 || q_b.size() != 25) begin
            failures++;
            $display("FAIL ovr2_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp2[i]) begin
                failures++;
                $display("FAIL ovr2_byte%0d got %h want %h",
                         i, q_b[i], exp2[i]);
            end
        end
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky got %b want 1", bus.overrun);
        end
    endtask

    task automatic test_midframe_reset();
        string exp = "A2468 V+0000 F1357 T1 -\r\n";
        int    n;
        int    fd0;
        bit    ok;
        set_in(16'h2468, 16'h0000, 16'h1357, 16'h0001, 1'b0, 1'b0);
        q_b.delete();
        fd0 = fd_cnt;
        send_pulse(n);
        wait_q(12, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.txclk !== 1'b0) begin
            failures++;
            $display("FAIL mrst_txclk got %b want 0", bus.txclk);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mrst_busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.txdata !== 8'h00) begin
            failures++;
            $display("FAIL mrst_txdata got %h want 00", bus.txdata);
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL mrst_overrun got %b want 0", bus.overrun);
        end
        checks++;
        if (q_b.size() != 12) begin
            failures++;
            $display("FAIL mrst_count got %0d want 12", q_b.size());
        end
        rst = 1'b0;
        tick();
        q_b.delete();
        send_pulse(n);
        wait_fd(fd0 + 1, ok);
        checks++;
        if (ok !== 1'b1 || q_b.size() != 25) begin
            failures++;
            $display("FAIL mrst_len got %0d want 25", q_b.size());
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp[i]) begin
                failures++;
                $display("FAIL mrst_byte%0d got %h want %h",
                         i, q_b[i], exp[i]);
            end
        end
    endtask

    task automatic test_bad_digit_noeol();
        string exp  = "A4?00 V+0000 F0800 T5 X\r\n";
        string exp0 = "A4?00 V+0000 F0800 T5 X";
        int    fd0;
        int    fdz;
        bit    ok;
        set_in(16'h4A00, 16'h0000, 16'h0800, 16'h0005, 1'b0, 1'b1);
        q_b.delete();
        q0_b.delete();
        fd0 = fd_cnt;
        fdz = fd0_cnt;
        tick();
        bus.send = 1'b1;
        bus0.send = 1'b1;
        tick();
        bus.send = 1'b0;
        bus0.send = 1'b0;
        wait_fd(fd0 + 1, ok);
        repeat (5) tick();
        checks++;
        if (q_b[2] !== 8'h3F) begin
            failures++;
            $display("FAIL qmark got %h want 3f", q_b[2]);
        end
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (q_b[i] !== exp[i]) begin
                failures++;
                $display("FAIL qm_byte%0d got %h want %h",
                         i, q_b[i], exp[i]);
            end
        end
        checks++;
        if (fd0_cnt != fdz + 1) begin
            failures++;
            $display("FAIL noeol_done got %0d want 1", fd0_cnt - fdz);
        end
        checks++;
        if (q0_b.size() != 23) begin
            failures++;
            $display("FAIL noeol_len got %0d want 23", q0_b.size());
        end
        checks++;
        if (q0_b[22] !== 8'h58) begin
            failures++;
            $display("FAIL noeol_last got %h want 58", q0_b[22]);
        end
        for (int i = 0; i < 23; i++) begin
            checks++;
            if (q0_b[i] !== exp0[i]) begin
                failures++;
                $display("FAIL noeol_byte%0d got %h want %h",
                         i, q0_b[i], exp0[i]);
            end
        end
        checks++;
        if (dbl !== 1'b0) begin
            failures++;
            $display("FAIL txclk_double got %b want 0", dbl);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_negative_vel();
        test_backpressure();
        test_overrun();
        test_midframe_reset();
        test_bad_digit_noeol();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
